// File: rtl/apb_req_bridge.sv
// Core req/gnt/r_valid to APB master bridge: IDLE -> SETUP -> ACCESS, one transfer in flight.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_BRIDGE_TIMEOUT_EN.
module apb_req_bridge #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      ACLK_i,
  input  logic                      ARESETn_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      r_valid_o,
  output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_opc_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  output logic                      PWRITE_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_reg;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

`ifdef APB_BRIDGE_TIMEOUT_EN
  // Abort fires on the ACCESS cycle whose stall would bring the count to TIMEOUT_CYCLES.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [APB_DATA_WIDTH-1:0] ABORT_DATA = APB_DATA_WIDTH'(32'hDEADBEEF);
  logic [15:0] wait_cnt_reg;
`endif

  assign gnt_o = req_i && (state_reg == IDLE);

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      state_reg <= IDLE;
      PSEL_o    <= 1'b0;
      PENABLE_o <= 1'b0;
      PWRITE_o  <= 1'b0;
      PADDR_o   <= '0;
      PWDATA_o  <= '0;
      r_valid_o <= 1'b0;
      r_rdata_o <= '0;
      r_opc_o   <= 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
      wait_cnt_reg <= '0;
`endif
    end else begin
      r_valid_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_i) begin
            PADDR_o   <= addr_i;
            PWRITE_o  <= we_i;
            PWDATA_o  <= wdata_i;
            PSEL_o    <= 1'b1;
            PENABLE_o <= 1'b0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          PENABLE_o <= 1'b1;
          state_reg <= ACCESS;
`ifdef APB_BRIDGE_TIMEOUT_EN
          wait_cnt_reg <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY_i) begin
            r_valid_o <= 1'b1;
            r_rdata_o <= PWRITE_o ? '0 : PRDATA_i;
            r_opc_o   <= PSLVERR_i;
            PSEL_o    <= 1'b0;
            PENABLE_o <= 1'b0;
            state_reg <= IDLE;
          end
`ifdef APB_BRIDGE_TIMEOUT_EN
          else if (wait_cnt_reg == TIMEOUT_LAST) begin
            r_valid_o    <= 1'b1;
            r_rdata_o    <= ABORT_DATA;
            r_opc_o      <= 1'b1;
            PSEL_o       <= 1'b0;
            PENABLE_o    <= 1'b0;
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
            state_reg    <= IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
`endif
        end
        default: begin
          PSEL_o    <= 1'b0;
          PENABLE_o <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_bridge.sv
// Randomized bench for apb_req_bridge; expected timing and response come from a transaction-level model.
// Build with +define+APB_BRIDGE_TIMEOUT_EN to also exercise the timeout abort.
module tb_apb_req_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          gnt;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          r_valid;
  logic [DW-1:0] r_rdata;
  logic          r_opc;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ACLK_i(clk), .ARESETn_i(rst_n),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .wdata_i(wdata),
    .r_valid_o(r_valid), .r_rdata_o(r_rdata), .r_opc_o(r_opc),
    .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite),
    .PADDR_o(paddr), .PWDATA_o(pwdata),
    .PRDATA_i(prdata), .PREADY_i(pready), .PSLVERR_i(pslverr)
  );

  // One transfer, entered and left at a negedge. The slave raises PREADY after
  // 'waits' stalled ACCESS cycles; a timeout (if built in) cuts ACCESS short.
  task automatic do_txn(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                        input int waits, input logic [DW-1:0] rd, input logic err,
                        output int gcyc);
    int n_acc;
    logic abort;
    logic [DW-1:0] exp_rdata;
    logic exp_opc, exp_pen, rdy;
    n_acc = waits + 1;
    abort = 1'b0;
`ifdef APB_BRIDGE_TIMEOUT_EN
    if (n_acc > TO) begin
      n_acc = TO;
      abort = 1'b1;
    end
`endif
    exp_rdata = abort ? DW'(32'hDEADBEEF) : (w ? '0 : rd);
    exp_opc = abort | err;
    req = 1'b1; addr = a; we = w; wdata = wd;
    #1;
    n_tests++;
    if (gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_idle: got %b want 1", gnt);
    end
    gcyc = cyc;
    @(posedge clk);
    for (int i = 1; i <= 1 + n_acc; i++) begin
      @(negedge clk);
      exp_pen = (i >= 2);
      n_tests++;
      if ({psel, penable, r_valid, paddr, pwrite, pwdata} !== {1'b1, exp_pen, 1'b0, a, w, wd}) begin
        n_fail++;
        $display("FAIL phase%0d: got sel=%b en=%b rv=%b addr=%h wr=%b wd=%h want sel=1 en=%b rv=0 addr=%h wr=%b wd=%h",
                 i, psel, penable, r_valid, paddr, pwrite, pwdata, exp_pen, a, w, wd);
      end
      req = 1'(($urandom & 1));
      addr = $urandom; we = 1'(($urandom & 1)); wdata = $urandom;
      rdy = (i == 1) ? 1'(($urandom & 1)) : (i - 1 == waits + 1);
      pready = rdy;
      prdata = rdy ? rd : $urandom;
      pslverr = rdy ? err : 1'(($urandom & 1));
      #1;
      n_tests++;
      if (gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_busy%0d: got %b want 0 (req=%b)", i, gnt, req);
      end
    end
    @(negedge clk);
    n_tests++;
    if ({r_valid, r_rdata, r_opc, psel, penable} !== {1'b1, exp_rdata, exp_opc, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL response: got rv=%b rdata=%h opc=%b sel=%b en=%b want rv=1 rdata=%h opc=%b sel=0 en=0",
               r_valid, r_rdata, r_opc, psel, penable, exp_rdata, exp_opc);
    end
    n_tests++;
    if (cyc - gcyc !== 3 + n_acc - 1) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", cyc - gcyc, 3 + n_acc - 1);
    end
    req = 1'b0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({psel, penable, r_valid} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle: got sel=%b en=%b rv=%b want 000", psel, penable, r_valid);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({gnt, r_valid, r_rdata, r_opc, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      n_fail++;
      $display("FAIL reset: got gnt=%b rv=%b rdata=%h opc=%b sel=%b en=%b wr=%b addr=%h wd=%h want all 0",
               gnt, r_valid, r_rdata, r_opc, psel, penable, pwrite, paddr, pwdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_read_zero_wait();
    int g;
    do_txn(32'h1A10_0004, 1'b0, 32'h0, 0, 32'hCAFE_0001, 1'b0, g);
    idle(1);
  endtask

  task automatic test_write_waits();
    int g;
    do_txn(32'h1A10_0010, 1'b1, 32'h1234_5678, 2, 32'hFFFF_FFFF, 1'b0, g);
    idle(1);
  endtask

  task automatic test_slave_error();
    int g;
    do_txn(32'h0000_0100, 1'b0, 32'h0, 1, 32'h5555_AAAA, 1'b1, g);
    do_txn(32'h0000_0104, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, g);
    idle(1);
  endtask

  task automatic test_back_to_back();
    int g0, g1, g2;
    do_txn(32'h10, 1'b0, 32'h0, 0, 32'h11, 1'b0, g0);
    do_txn(32'h14, 1'b1, 32'h22, 0, 32'h0, 1'b0, g1);
    do_txn(32'h18, 1'b0, 32'h0, 0, 32'h33, 1'b0, g2);
    n_tests++;
    if ((g1 - g0 !== 3) || (g2 - g1 !== 3)) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d,%0d want 3,3", g1 - g0, g2 - g1);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    req = 1'b1; addr = 32'hABCD_0000; we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    pready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({psel, penable, r_valid, paddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got sel=%b en=%b rv=%b addr=%h want all 0", psel, penable, r_valid, paddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    test_read_zero_wait();
  endtask

  task automatic test_timeout();
    int g;
    do_txn(32'h2000, 1'b0, 32'h0, 3, 32'h7777_1234, 1'b0, g);
    idle(1);
    do_txn(32'h2004, 1'b0, 32'h0, 20, 32'h7777_5678, 1'b0, g);
    idle(1);
  endtask

  task automatic test_random();
    int g, w;
    for (int t = 0; t < 30; t++) begin
      w = $urandom_range(0, 5);
      do_txn($urandom, 1'(($urandom & 1)), $urandom, w, $urandom, 1'(($urandom & 1)), g);
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_slave_error();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
